// File: rtl/mod3_pkg.sv
// Shared constants for the modulo-3 counter and its monitor.
// Counter codes and monitor state encodings.
package mod3_pkg;

  localparam logic [1:0] MOD3_S0  = 2'b00;
  localparam logic [1:0] MOD3_S1  = 2'b01;
  localparam logic [1:0] MOD3_S2  = 2'b10;
  localparam logic [1:0] MOD3_ILL = 2'b11;

  typedef enum logic [1:0] {
    MON_IDLE  = 2'b00,
    MON_TRACK = 2'b01,
    MON_FAULT = 2'b10
  } mon_state_e;

endpackage

// File: rtl/mod3_successor.sv
// Combinational modulo-3 successor.
// The illegal code maps to itself so it never matches a legal step.
module mod3_successor
  import mod3_pkg::*;
(
  input  logic [1:0] cur,
  output logic [1:0] nxt
);

  // Next code in the 0 -> 1 -> 2 -> 0 sequence
  always_comb begin
    nxt = MOD3_ILL;
    unique case (cur)
      MOD3_S0:  nxt = MOD3_S1;
      MOD3_S1:  nxt = MOD3_S2;
      MOD3_S2:  nxt = MOD3_S0;
      MOD3_ILL: nxt = MOD3_ILL;
      default:  nxt = MOD3_ILL;
    endcase
  end

endmodule

// File: rtl/counter_modulo3_monitor.sv
// Sequence checker for the modulo-3 counter.
// Tracks steps, counts wraps, latches sticky errors.
module counter_modulo3_monitor
  import mod3_pkg::*;
#(
  parameter int WRAP_W   = 8,
  parameter bit CHK_COMP = 1'b1
) (
  input  logic              clockpulse,
  input  logic              clear_,
  input  logic [1:0]        signal_q,
  input  logic [1:0]        signal_q_,
  output logic [1:0]        o_q_prev,
  output logic              o_wrap_pulse,
  output logic [WRAP_W-1:0] o_wrap_count,
  output logic              o_err_illegal,
  output logic              o_err_skip,
  output logic              o_err_comp,
  output logic              o_fault
);

  mon_state_e state_q;
  mon_state_e state_d;

  logic [1:0] exp_q;
  logic       is_ill;
  logic       comp_bad;
  logic       skip_bad;
  logic       ill_d;
  logic       skip_d;
  logic       comp_d;
  logic       pulse_d;
  logic       cnt_inc;

  mod3_successor u_succ (
    .cur (o_q_prev),
    .nxt (exp_q)
  );

  assign is_ill   = (signal_q == MOD3_ILL);
  assign comp_bad = CHK_COMP && (signal_q_ != ~signal_q);
  assign skip_bad = !is_ill && (signal_q != exp_q);
  assign o_fault  = (state_q == MON_FAULT);

  // Next state, sticky flag updates and wrap detection
  always_comb begin
    state_d = state_q;
    ill_d   = o_err_illegal;
    skip_d  = o_err_skip;
    comp_d  = o_err_comp;
    pulse_d = 1'b0;
    cnt_inc = 1'b0;
    unique case (state_q)
      MON_IDLE: begin
        if (is_ill)   ill_d  = 1'b1;
        if (comp_bad) comp_d = 1'b1;
        if (is_ill || comp_bad)
          state_d = MON_FAULT;
        else
          state_d = MON_TRACK;
      end
      MON_TRACK: begin
        if (is_ill)   ill_d  = 1'b1;
        if (skip_bad) skip_d = 1'b1;
        if (comp_bad) comp_d = 1'b1;
        if (is_ill || skip_bad || comp_bad) begin
          state_d = MON_FAULT;
        end else if (o_q_prev == MOD3_S2 &&
                     signal_q == MOD3_S0) begin
          pulse_d = 1'b1;
          cnt_inc = 1'b1;
        end
      end
      MON_FAULT: state_d = MON_FAULT;
      default:   state_d = MON_FAULT;
    endcase
  end

  // State, sample and flag registers
  always_ff @(posedge clockpulse or negedge clear_) begin
    if (!clear_) begin
      state_q       <= MON_IDLE;
      o_q_prev      <= MOD3_S0;
      o_wrap_pulse  <= 1'b0;
      o_err_illegal <= 1'b0;
      o_err_skip    <= 1'b0;
      o_err_comp    <= 1'b0;
    end else begin
      state_q       <= state_d;
      o_q_prev      <= signal_q;
      o_wrap_pulse  <= pulse_d;
      o_err_illegal <= ill_d;
      o_err_skip    <= skip_d;
      o_err_comp    <= comp_d;
    end
  end

  // Saturating wrap counter
  always_ff @(posedge clockpulse or negedge clear_) begin
    if (!clear_)
      o_wrap_count <= '0;
    else if (cnt_inc && o_wrap_count != '1)
      o_wrap_count <= o_wrap_count + WRAP_W'(1);
  end

endmodule
